// File: rtl/reg_writeback.sv
// reg_writeback: write-side sequencer for the 8x8-bit register file.
// Buffers execution results in a DEPTH-entry circular FIFO and drains one
// write per clock into a registered enable/address/data write port.
// Also answers pending-write lookups for two decode read ports.
// Optional feature macro: WB_FORWARD_EN (builds the youngest-value bypass mux).
module reg_writeback #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       res_valid,
   output logic       res_ready,
   input  logic [2:0] res_addr,
   input  logic [7:0] res_data,
   input  logic       wr_stall,
   output logic       reg_en,
   output logic [2:0] wr_addr,
   output logic [7:0] data,
   input  logic [2:0] rd_addr1,
   input  logic [2:0] rd_addr2,
   output logic       hit1,
   output logic       hit2,
   output logic [7:0] fwd_data1,
   output logic [7:0] fwd_data2
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [2:0] addr;
      logic [7:0] data;
   } wb_ent_t;

   wb_ent_t       fifo [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          push, pop;

   // Ready depends only on registered occupancy plus flush/reset, never on
   // the stall input, so the producer sees no combinational loop.
   assign res_ready = (count != FULL) && !flush && rst;
   assign push      = res_valid && res_ready;
   assign pop       = (count != '0) && !wr_stall && !flush;

   // Payload storage; entries are only ever read while counted valid.
   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= {res_addr, res_data};
   end

   // Pointers, occupancy and the registered write port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         reg_en  <= 1'b0;
         wr_addr <= '0;
         data    <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         reg_en  <= 1'b0;
      end else begin
         reg_en <= pop;
         if (pop) begin
            wr_addr <= fifo[rd_ptr].addr;
            data    <= fifo[rd_ptr].data;
            rd_ptr  <= rd_ptr + 1'b1;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   logic [1:0][2:0] rd_v;
   logic [1:0]      hit_v;
   assign rd_v = {rd_addr2, rd_addr1};

`ifdef WB_FORWARD_EN
   logic [1:0][7:0] fwd_v;
`endif

   // Hazard lookup: start from the output stage, then walk FIFO entries
   // oldest to newest so the youngest match is the one left standing.
   always_comb begin
      hit_v = '0;
`ifdef WB_FORWARD_EN
      fwd_v = '0;
`endif
      for (int p = 0; p < 2; p++) begin
         if (reg_en && (wr_addr == rd_v[p])) begin
            hit_v[p] = 1'b1;
`ifdef WB_FORWARD_EN
            fwd_v[p] = data;
`endif
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (((AW+1)'(i) < count) &&
                (fifo[rd_ptr + AW'(i)].addr == rd_v[p])) begin
               hit_v[p] = 1'b1;
`ifdef WB_FORWARD_EN
               fwd_v[p] = fifo[rd_ptr + AW'(i)].data;
`endif
            end
         end
      end
   end

   assign hit1 = hit_v[0];
   assign hit2 = hit_v[1];

`ifdef WB_FORWARD_EN
   assign fwd_data1 = fwd_v[0];
   assign fwd_data2 = fwd_v[1];
`else
   assign fwd_data1 = 8'h00;
   assign fwd_data2 = 8'h00;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: randomized bench with a queue-based reference model of
// the write buffer, a per-cycle compare process, and directed scenarios
// whose literal expectations pin the model.
module tb_reg_writeback;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst, flush, res_valid, res_ready, wr_stall;
   logic [2:0] res_addr, wr_addr, rd_addr1, rd_addr2;
   logic [7:0] res_data, data, fwd_data1, fwd_data2;
   logic       reg_en, hit1, hit2;

   reg_writeback #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_addr(res_addr), .res_data(res_data),
      .wr_stall(wr_stall), .reg_en(reg_en), .wr_addr(wr_addr), .data(data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .hit1(hit1), .hit2(hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] a;
      logic [7:0] d;
   } ent_t;

   int nvec = 0;
   int nmis = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending writes as an ordered queue, plus the write port.
   ent_t       q[$];
   logic       m_en = 1'b0;
   logic [2:0] m_addr = '0;
   logic [7:0] m_data = '0;
   bit         m_push;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_en = 1'b0; m_addr = '0; m_data = '0;
      end else begin
         m_push = res_valid && !flush && (q.size() != DEPTH);
         if (flush) begin
            q.delete();
            m_en = 1'b0;
         end else begin
            if (q.size() != 0 && !wr_stall) begin
               m_en = 1'b1; m_addr = q[0].a; m_data = q[0].d;
               void'(q.pop_front());
            end else begin
               m_en = 1'b0;
            end
            if (m_push) q.push_back({res_addr, res_data});
         end
      end
   end

   // Youngest pending value for an address: newest queue entry, then port.
   function automatic logic [8:0] look(input logic [2:0] a);
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].a == a) return {1'b1, q[i].d};
      if (m_en && m_addr == a) return {1'b1, m_data};
      return 9'h000;
   endfunction

   function automatic logic [7:0] exp_fwd(input logic [8:0] l);
`ifdef WB_FORWARD_EN
      return l[7:0];
`else
      return (l[8]) ? 8'h00 : l[7:0] & 8'h00;
`endif
   endfunction

   ent_t issued[$];
   logic [8:0] l1, l2;

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      l1 = look(rd_addr1);
      l2 = look(rd_addr2);
      check("res_ready", {31'b0, res_ready}, {31'b0, rst && !flush && (q.size() != DEPTH)});
      check("reg_en",    {31'b0, reg_en},    {31'b0, m_en});
      check("wr_addr",   {29'b0, wr_addr},   {29'b0, m_addr});
      check("data",      {24'b0, data},      {24'b0, m_data});
      check("hit1",      {31'b0, hit1},      {31'b0, l1[8]});
      check("hit2",      {31'b0, hit2},      {31'b0, l2[8]});
      check("fwd_data1", {24'b0, fwd_data1}, {24'b0, exp_fwd(l1)});
      check("fwd_data2", {24'b0, fwd_data2}, {24'b0, exp_fwd(l2)});
      if (reg_en) issued.push_back({wr_addr, data});
   end

   task automatic cyc(input logic v, input logic [2:0] a, input logic [7:0] d,
                      input logic st, input logic fl);
      res_valid = v; res_addr = a; res_data = d; wr_stall = st; flush = fl;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   int stall_mode;

   initial begin
      rst = 1'b1; flush = 0; res_valid = 0; res_addr = 0; res_data = 0;
      wr_stall = 0; rd_addr1 = 0; rd_addr2 = 0;
      #1 rst = 1'b0; res_valid = 1'b1;
      // Reset held with a result offered: nothing accepted, port at zero.
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",  {31'b0, res_ready}, 32'd0);
      check("rst_reg_en", {31'b0, reg_en},    32'd0);
      check("rst_waddr",  {29'b0, wr_addr},   32'd0);
      check("rst_data",   {24'b0, data},      32'd0);
      rst = 1'b1; res_valid = 1'b0;
      #1 check("rel_ready", {31'b0, res_ready}, 32'd1);

      // Single write: accepted at N, on the port after N+1, gone after N+2.
      rd_addr1 = 3'd3; rd_addr2 = 3'd0;
      cyc(1, 3'd3, 8'hAA, 0, 0);
      check("sw_en_n", {31'b0, reg_en}, 32'd0);
      cyc(0, 3'd0, 8'h00, 0, 0);
      check("sw_en_n1", {31'b0, reg_en},  32'd1);
      check("sw_addr",  {29'b0, wr_addr}, 32'd3);
      check("sw_data",  {24'b0, data},    32'hAA);
      cyc(0, 3'd0, 8'h00, 0, 0);
      check("sw_en_n2", {31'b0, reg_en}, 32'd0);

      // Back-pressure: four stalled pushes fill the buffer.
      cyc(1, 3'd1, 8'h11, 1, 0);
      cyc(1, 3'd2, 8'h22, 1, 0);
      cyc(1, 3'd3, 8'h33, 1, 0);
      cyc(1, 3'd4, 8'h44, 1, 0);
      check("full_ready", {31'b0, res_ready}, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         cyc(0, 3'd0, 8'h00, 0, 0);
         check("drain_en",   {31'b0, reg_en},  32'd1);
         check("drain_addr", {29'b0, wr_addr}, i);
         check("drain_data", {24'b0, data},    i * 32'h11);
         if (i == 1) check("drain_ready", {31'b0, res_ready}, 32'd1);
      end
      cyc(0, 3'd0, 8'h00, 0, 0);
      check("drain_done", {31'b0, reg_en}, 32'd0);

      // Forwarding: two stalled writes to reg2, youngest must be reported.
      rd_addr1 = 3'd2; rd_addr2 = 3'd5;
      cyc(1, 3'd2, 8'h10, 1, 0);
      cyc(1, 3'd2, 8'h20, 1, 0);
      check("fw_hit1", {31'b0, hit1}, 32'd1);
      check("fw_hit2", {31'b0, hit2}, 32'd0);
`ifdef WB_FORWARD_EN
      check("fw_data1", {24'b0, fwd_data1}, 32'h20);
`else
      check("fw_data1", {24'b0, fwd_data1}, 32'h00);
`endif
      check("fw_data2", {24'b0, fwd_data2}, 32'h00);

      // Flush with three pending and a result offered.
      cyc(1, 3'd7, 8'h77, 1, 0);
      rd_addr2 = 3'd6;
      cyc(1, 3'd6, 8'h66, 0, 1);
      flush = 1'b0; res_valid = 1'b0;
      #1;
      check("fl_reg_en", {31'b0, reg_en},    32'd0);
      check("fl_ready",  {31'b0, res_ready}, 32'd1);
      check("fl_hit1",   {31'b0, hit1},      32'd0);
      check("fl_hit2",   {31'b0, hit2},      32'd0);
      cyc(0, 3'd0, 8'h00, 0, 0);
      check("fl_nowrite", {31'b0, reg_en}, 32'd0);

      // Wrap-around: 2*DEPTH+1 sequential writes, each issued once, in order.
      issued.delete();
      for (int i = 0; i < 2 * DEPTH + 1; i++) cyc(1, 3'(i % 8), 8'(i), 0, 0);
      repeat (3) cyc(0, 3'd0, 8'h00, 0, 0);
      check("wrap_count", issued.size(), 2 * DEPTH + 1);
      for (int i = 0; i < issued.size() && i < 2 * DEPTH + 1; i++) begin
         check("wrap_addr", {29'b0, issued[i].a}, i % 8);
         check("wrap_data", {24'b0, issued[i].d}, i);
      end

      // Randomized traffic with stall bursts, rare flushes, one async reset.
      stall_mode = 0;
      for (int n = 0; n < 1500; n++) begin
         if (n % 32 == 0) stall_mode = $urandom_range(0, 3);
         rd_addr1 = 3'($urandom);
         rd_addr2 = 3'($urandom);
         if (n == 700) begin
            res_valid = 1'b1; wr_stall = 1'b1; flush = 1'b0;
            @(posedge clk); #3;
            rst = 1'b0;
            #1;
            check("ar_reg_en", {31'b0, reg_en},    32'd0);
            check("ar_ready",  {31'b0, res_ready}, 32'd0);
            check("ar_hit1",   {31'b0, hit1},      32'd0);
            check("ar_waddr",  {29'b0, wr_addr},   32'd0);
            @(posedge clk); #1;
            rst = 1'b1;
         end
         cyc(($urandom % 4) != 0, 3'($urandom), 8'($urandom),
             (stall_mode == 3) ? 1'b1 : (stall_mode == 0) ? 1'b0 : (($urandom % 3) == 0),
             ($urandom % 64) == 0);
      end
      repeat (2 * DEPTH) cyc(0, 3'd0, 8'h00, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
